pulse_gate_ctrl: RTL
====================

# pulse_gate_ctrl

Sequencing controller for the pulse-counter datapath. It synchronises the raw PULSE input, opens a programmable gate window, issues INC per detected pulse edge, and issues SCLR at window start and LOAD at window end. LOAD is issued only when the downstream result holder is free, tracked through a valid/ready handshake. It sits between the external pulse source, the counter/result-register datapath, and the consumer that reads measurements.

## Interface
- GATE_W, 16, width of gate-length operand and internal gate timer
- SYNC_STAGES, 2, flip-flop stages on PULSE before edge detection (≥2)

- SYS_CLK  in  1  system clock, all logic on rising edge
- S_RESET_N  in  1  reset, synchronous, active-low
- PULSE  in  1  raw asynchronous pulse input
- START  in  1  one-cycle request to begin a measurement; honoured only in IDLE
- CONT  in  1  continuous mode, sampled with START
- ABORT  in  1  terminate current measurement
- GATE_LEN  in  GATE_W  gate window length in SYS_CLK cycles, sampled with START
- RES_READY  in  1  consumer accepts result
- INC  out  1  increment datapath counter
- SCLR  out  1  synchronous clear of datapath counter
- LOAD  out  1  copy counter into result register
- BUSY  out  1  high in any state other than IDLE
- RES_VALID  out  1  result register holds an unconsumed measurement
- OVERRUN  out  1  sticky: a window ended while a result was still pending

## Operation
- Input path: PULSE passes through SYNC_STAGES flops, then a one-flop history. Edge = synced & ~history. The edge path runs in every state. A level already high at START is never counted as an edge.
- States: IDLE, CLEAR, GATE, WAIT, LATCH. The encoding is free.
- IDLE: all strobes 0.
  - START=1 with GATE_LEN≠0: capture GATE_LEN and CONT, clear OVERRUN, go to CLEAR.
  - START with GATE_LEN=0: ignored, stay IDLE.
- CLEAR: SCLR=1 for exactly one cycle. Gate timer loads captured length. Go to GATE. Edges in this cycle are not counted.
- GATE: INC = edge, every cycle. Timer decrements each cycle. On the cycle the timer reads 1, that cycle's edge is still counted. Next state:
  - WAIT if RES_VALID=1 and RES_READY=0 in that cycle.
  - Otherwise LATCH.
  - A gate length of N gives exactly N GATE cycles.
- WAIT: INC=0; edges are dropped. OVERRUN sets on entry. Go to LATCH in the cycle after RES_VALID=0 or RES_READY=1 is seen.
- LATCH: LOAD=1 for exactly one cycle, INC=0. Next state is CLEAR if the captured CONT=1, else IDLE.
- RES_VALID:
  - Set on the cycle after LOAD.
  - Cleared on the cycle after RES_VALID&RES_READY.
  - Set has priority over clear.
- At most one of INC, SCLR, LOAD is high in any cycle.
- ABORT: from any state, go to IDLE next cycle, all strobes 0 that cycle. No LOAD is issued. RES_VALID and OVERRUN are unchanged. ABORT wins over a simultaneous START.
- START outside IDLE is ignored; captured GATE_LEN and CONT do not change mid-measurement.
- Timer width is GATE_W; maximum window is 2^GATE_W−1 cycles, with no wrap.

## Timing
- Reset (S_RESET_N=0 at a clock edge): state=IDLE; INC=SCLR=LOAD=BUSY=RES_VALID=OVERRUN=0; sync and history flops=0. Reset mid-measurement discards it silently.
- PULSE rising (sampled at edge k) to INC=1: in cycle k+SYNC_STAGES, if in GATE. PULSE high and low phases must each be ≥1 SYS_CLK period to be counted.
- START (cycle t) → SCLR in t+1 → GATE cycles t+2 … t+1+N → LOAD in t+2+N if no stall → RES_VALID=1 from t+3+N.
- Continuous mode: SCLR follows LOAD by 1 cycle, so the dead time between windows is 2 cycles (LATCH, CLEAR).
- Each WAIT cycle adds 1 cycle of latency; minimum WAIT residence is 1 cycle.
- BUSY rises the cycle after START and falls the cycle after LATCH (one-shot) or after ABORT.

## Test plan
- Reset: hold S_RESET_N=0 with START=1, PULSE toggling → all outputs 0, no state change; release → IDLE, BUSY=0.
- One-shot: GATE_LEN=10, 4 clean pulses inside window, RES_READY=1 → exactly 4 INC, SCLR at t+1, LOAD at t+12, RES_VALID high from t+13 for one cycle.
- Edge boundaries: GATE_LEN=1, pulse timed so its INC lands in the single GATE cycle → 1 INC then LOAD. PULSE already high at START → 0 INC.
- Stall: CONT=1, GATE_LEN=5, RES_READY=0 → first window LOADs; second window enters WAIT, OVERRUN=1, no LOAD and no INC while RES_READY=0. Raise RES_READY → LOAD next cycle, then SCLR.
- ABORT/START conflicts: ABORT in GATE cycle 3 of 8 → IDLE next cycle, no LOAD. ABORT+START same cycle in IDLE → stays IDLE. START with GATE_LEN=0 → ignored.
- Strobe exclusivity: random PULSE and RES_READY, 10k cycles, CONT=1 → INC/SCLR/LOAD never overlap. INC count per window matches a reference model of synchronised edges.

Source files
------------

// File: rtl/pulse_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_gate_ctrl
//  Purpose  : Gate-window sequencer that issues SCLR/INC/LOAD strobes to a
//             pulse-counter datapath, with a valid/ready result handshake.
//  Revision : 1.0  initial release
// ============================================================================
module pulse_gate_ctrl #(
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              SYS_CLK,
  input  logic              S_RESET_N,
  input  logic              PULSE,
  input  logic              START,
  input  logic              CONT,
  input  logic              ABORT,
  input  logic [GATE_W-1:0] GATE_LEN,
  input  logic              RES_READY,
  output logic              INC,
  output logic              SCLR,
  output logic              LOAD,
  output logic              BUSY,
  output logic              RES_VALID,
  output logic              OVERRUN
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_GATE  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [GATE_W-1:0]      r_len;
  logic [GATE_W-1:0]      r_timer;
  logic                   r_cont;
  logic                   r_res_valid;
  logic                   r_overrun;
  logic                   w_edge;
  logic                   w_inc;
  logic                   w_sclr;
  logic                   w_load;
  logic                   w_accept;
  logic                   w_stall;

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

  always_ff @(posedge SYS_CLK) begin
    if (!S_RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_inc       = 1'b0;
    w_sclr      = 1'b0;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START && (GATE_LEN != '0)) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_sclr      = 1'b1;
        w_state_nxt = ST_GATE;
      end
      ST_GATE: begin
        w_inc = w_edge;
        if (r_timer == GATE_W'(1)) begin
          // Result holder still occupied: park until the consumer drains it.
          if (r_res_valid && !RES_READY) begin
            w_stall     = 1'b1;
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_LATCH;
          end
        end
      end
      ST_WAIT: begin
        if (!r_res_valid || RES_READY) begin
          w_state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: begin
        w_load      = 1'b1;
        w_state_nxt = r_cont ? ST_CLEAR : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Abort silences every strobe in its own cycle so no partial result loads.
    if (ABORT) begin
      w_state_nxt = ST_IDLE;
      w_inc       = 1'b0;
      w_sclr      = 1'b0;
      w_load      = 1'b0;
      w_accept    = 1'b0;
      w_stall     = 1'b0;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (!S_RESET_N) begin
      r_sync      <= '0;
      r_hist      <= 1'b0;
      r_len       <= '0;
      r_timer     <= '0;
      r_cont      <= 1'b0;
      r_res_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], PULSE};
      r_hist <= r_sync[SYNC_STAGES-1];
      if (w_accept) begin
        r_len  <= GATE_LEN;
        r_cont <= CONT;
      end
      if (r_state == ST_CLEAR) begin
        r_timer <= r_len;
      end else if (r_state == ST_GATE) begin
        r_timer <= r_timer - GATE_W'(1);
      end
      if (w_accept) begin
        r_overrun <= 1'b0;
      end else if (w_stall) begin
        r_overrun <= 1'b1;
      end
      if (w_load) begin
        r_res_valid <= 1'b1;
      end else if (r_res_valid && RES_READY) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign INC       = w_inc;
  assign SCLR      = w_sclr;
  assign LOAD      = w_load;
  assign BUSY      = (r_state != ST_IDLE);
  assign RES_VALID = r_res_valid;
  assign OVERRUN   = r_overrun;

endmodule
`default_nettype wire
